// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller for a 5-stage in-order pipeline: tracks in-flight writers, decides RUN/STALL/MEMWAIT/FLUSH.
// Optional macro PIPE_FORWARD_EN: forwarding is assumed, so only a load in EX can cause a stall.
module pipe_hazard_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [3:0] id_opcode,
    input  logic [2:0] id_operanda,
    input  logic [2:0] id_operandb,
    input  logic [2:0] id_dest,
    input  logic       br_taken,
    input  logic       mem_busy,
    output logic       pc_en,
    output logic       ifid_en,
    output logic       ifid_flush,
    output logic       idex_bubble,
    output logic       pipe_en,
    output logic [1:0] state,
    output logic [7:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_STALL   = 2'b01,
        ST_MEMWAIT = 2'b10,
        ST_FLUSH   = 2'b11
    } ctrl_state_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] dest;
        logic       is_load;
    } sb_entry_t;

    ctrl_state_t state_q;
    ctrl_state_t state_d;
    sb_entry_t   sb [0:2];
    logic        rd_a;
    logic        rd_b;
    logic        wr;
    logic        ld;
    logic [2:0]  match;
    logic        hazard;
    logic        issue;
    logic [7:0]  cnt_q;

    always_comb begin
        rd_a = 1'b0;
        rd_b = 1'b0;
        wr   = 1'b0;
        ld   = 1'b0;
        case (id_opcode)
            4'b0001, 4'b0010, 4'b0011, 4'b0100,
            4'b0101, 4'b0110, 4'b0111: begin
                rd_a = 1'b1;
                rd_b = 1'b1;
                wr   = 1'b1;
            end
            4'b1000: begin
                wr = 1'b1;
                ld = 1'b1;
            end
            4'b1001: rd_a = 1'b1;
            4'b1100: begin
                rd_a = 1'b1;
                rd_b = 1'b1;
            end
            default: ;
        endcase
    end

    // Index 0 = EX, 1 = MEM, 2 = WB.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            match[i] = sb[i].valid &
                       ((rd_a && (id_operanda == sb[i].dest)) ||
                        (rd_b && (id_operandb == sb[i].dest)));
        end
`ifdef PIPE_FORWARD_EN
        hazard = id_valid & match[0] & sb[0].is_load;
`else
        hazard = id_valid & (|match);
`endif
    end

    assign issue = id_valid & ~hazard & ~br_taken & ~mem_busy;

    always_comb begin
        state_d     = ST_RUN;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_en     = 1'b1;
        if (mem_busy) begin
            state_d = ST_MEMWAIT;
            pc_en   = 1'b0;
            ifid_en = 1'b0;
            pipe_en = 1'b0;
        end else if (br_taken) begin
            state_d     = ST_FLUSH;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (hazard) begin
            state_d     = ST_STALL;
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
        end
        // Reset holds the front end and keeps a NOP entering ID/EX.
        if (rst) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b0;
            idex_bubble = 1'b1;
            pipe_en     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                sb[i] <= '0;
            end
        end else if (!mem_busy) begin
            sb[2] <= sb[1];
            sb[1] <= sb[0];
            sb[0] <= issue ? sb_entry_t'{valid: wr, dest: id_dest, is_load: ld} : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else if ((state_d != ST_RUN) && (cnt_q != 8'hff)) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign state     = state_q;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: each step pushes its expected control word, decision and
// stall count to a queue, which is popped and compared once the DUT has produced them.
module tb_pipe_hazard_ctrl;

    // Control word order: {pc_en, ifid_en, ifid_flush, idex_bubble, pipe_en}
    localparam logic [4:0] C_RUN  = 5'b11001;
    localparam logic [4:0] C_STL  = 5'b00011;
    localparam logic [4:0] C_MW   = 5'b00000;
    localparam logic [4:0] C_FL   = 5'b11111;
    localparam logic [4:0] C_RST  = 5'b00010;
    localparam logic [1:0] S_RUN  = 2'b00;
    localparam logic [1:0] S_STL  = 2'b01;
    localparam logic [1:0] S_MW   = 2'b10;
    localparam logic [1:0] S_FL   = 2'b11;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [3:0] id_opcode;
    logic [2:0] id_operanda;
    logic [2:0] id_operandb;
    logic [2:0] id_dest;
    logic       br_taken;
    logic       mem_busy;
    logic       pc_en;
    logic       ifid_en;
    logic       ifid_flush;
    logic       idex_bubble;
    logic       pipe_en;
    logic [1:0] state;
    logic [7:0] stall_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_cnt;
    logic [14:0] exp_q [$];

    pipe_hazard_ctrl dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_operanda(id_operanda), .id_operandb(id_operandb), .id_dest(id_dest),
        .br_taken(br_taken), .mem_busy(mem_busy), .pc_en(pc_en), .ifid_en(ifid_en),
        .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .pipe_en(pipe_en),
        .state(state), .stall_cnt(stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ctrl_word();
        return {3'b000, pc_en, ifid_en, ifid_flush, idex_bubble, pipe_en};
    endfunction

    // Called just after a rising edge; drives one cycle of inputs and checks its results.
    task automatic step(input logic v, input logic [3:0] op, input logic [2:0] a,
                        input logic [2:0] b, input logic [2:0] d, input logic br,
                        input logic mb, input logic [4:0] ec, input logic [1:0] es);
        logic [14:0] e;
        id_valid    = v;
        id_opcode   = op;
        id_operanda = a;
        id_operandb = b;
        id_dest     = d;
        br_taken    = br;
        mem_busy    = mb;
        if ((es != S_RUN) && (exp_cnt != 8'hff)) exp_cnt = exp_cnt + 8'd1;
        exp_q.push_back({ec, es, exp_cnt});
        #2;
        e = exp_q.pop_front();
        check_val("ctrl", ctrl_word(), {3'b000, e[14:10]});
        @(posedge clk);
        #1;
        check_val("state", {6'b0, state}, {6'b0, e[9:8]});
        check_val("stall_cnt", stall_cnt, e[7:0]);
    endtask

    initial begin
        rst = 1'b1;
        id_valid = 1'b0; id_opcode = 4'h0; id_operanda = 3'd0; id_operandb = 3'd0;
        id_dest = 3'd0; br_taken = 1'b0; mem_busy = 1'b0;
        exp_cnt = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        check_val("reset_ctrl", ctrl_word(), {3'b000, C_RST});
        check_val("reset_state", {6'b0, state}, 8'd0);
        check_val("reset_cnt", stall_cnt, 8'd0);
        rst = 1'b0;

        step(0, 4'h0, 3'd0, 3'd0, 3'd0, 0, 0, C_RUN, S_RUN);
        // ALU writes r3, dependent ALU reads r3
        step(1, 4'h1, 3'd1, 3'd2, 3'd3, 0, 0, C_RUN, S_RUN);
`ifdef PIPE_FORWARD_EN
        step(1, 4'h2, 3'd3, 3'd4, 3'd6, 0, 0, C_RUN, S_RUN);
`else
        repeat (3) step(1, 4'h2, 3'd3, 3'd4, 3'd6, 0, 0, C_STL, S_STL);
        check_val("stall_cnt_after_raw", stall_cnt, 8'd3);
        step(1, 4'h2, 3'd3, 3'd4, 3'd6, 0, 0, C_RUN, S_RUN);
`endif
        repeat (3) step(0, 4'h0, 3'd0, 3'd0, 3'd0, 0, 0, C_RUN, S_RUN);

        // LOAD r5 then STORE reading r5, with a memory wait inside the stall
        step(1, 4'h8, 3'd0, 3'd0, 3'd5, 0, 0, C_RUN, S_RUN);
`ifdef PIPE_FORWARD_EN
        repeat (4) step(1, 4'h9, 3'd5, 3'd1, 3'd0, 0, 1, C_MW, S_MW);
        step(1, 4'h9, 3'd5, 3'd1, 3'd0, 0, 0, C_STL, S_STL);
`else
        step(1, 4'h9, 3'd5, 3'd1, 3'd0, 0, 0, C_STL, S_STL);
        repeat (4) step(1, 4'h9, 3'd5, 3'd1, 3'd0, 0, 1, C_MW, S_MW);
        repeat (2) step(1, 4'h9, 3'd5, 3'd1, 3'd0, 0, 0, C_STL, S_STL);
`endif
        step(1, 4'h9, 3'd5, 3'd1, 3'd0, 0, 0, C_RUN, S_RUN);

`ifdef PIPE_FORWARD_EN
        // LOAD r5 then ALU reading b=r5: exactly one stall
        step(1, 4'h8, 3'd0, 3'd0, 3'd5, 0, 0, C_RUN, S_RUN);
        step(1, 4'h3, 3'd1, 3'd5, 3'd2, 0, 0, C_STL, S_STL);
        step(1, 4'h3, 3'd1, 3'd5, 3'd2, 0, 0, C_RUN, S_RUN);
        repeat (3) step(0, 4'h0, 3'd0, 3'd0, 3'd0, 0, 0, C_RUN, S_RUN);
`endif

        // Branch flush: the flushed ALU (dest r7) must not enter the scoreboard
        step(1, 4'h2, 3'd0, 3'd1, 3'd2, 0, 0, C_RUN, S_RUN);
        step(1, 4'h3, 3'd2, 3'd1, 3'd7, 1, 0, C_FL, S_FL);
        step(1, 4'h4, 3'd7, 3'd7, 3'd1, 0, 0, C_RUN, S_RUN);
        // Branch during a memory wait with a hazard present: wait wins, then flush
        step(1, 4'h5, 3'd1, 3'd1, 3'd0, 1, 1, C_MW, S_MW);
        step(1, 4'h5, 3'd1, 3'd1, 3'd0, 1, 0, C_FL, S_FL);
        step(0, 4'h0, 3'd0, 3'd0, 3'd0, 0, 0, C_RUN, S_RUN);

        // Long wait during a load-use stall: counter saturates at 255
        step(1, 4'h8, 3'd0, 3'd0, 3'd4, 0, 0, C_RUN, S_RUN);
        for (int i = 0; i < 300; i++) begin
            step(1, 4'h1, 3'd4, 3'd4, 3'd1, 0, 1, C_MW, S_MW);
        end
        check_val("cnt_saturated", stall_cnt, 8'hff);

        // Reset mid-stall: clears immediately, hazard discarded after release
        mem_busy = 1'b0;
        #2;
        check_val("stall_before_rst", ctrl_word(), {3'b000, C_STL});
        rst = 1'b1;
        #1;
        check_val("midrst_ctrl", ctrl_word(), {3'b000, C_RST});
        check_val("midrst_state", {6'b0, state}, 8'd0);
        check_val("midrst_cnt", stall_cnt, 8'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_cnt = 8'd0;
        step(0, 4'h0, 3'd0, 3'd0, 3'd0, 0, 0, C_RUN, S_RUN);
        step(1, 4'h1, 3'd4, 3'd4, 3'd1, 0, 0, C_RUN, S_RUN);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed: opcode 4, register index 3, stall counter 8.
REQ-002 The block SHALL have these ports; reset is rst, asynchronous, active-high, and the clock is clk:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- id_valid  in  1  ID-stage instruction present
- id_opcode  in  4  ID-stage opcode
- id_operanda  in  3  source register a
- id_operandb  in  3  source register b
- id_dest  in  3  destination register
- br_taken  in  1  branch in EX resolved taken, this cycle
- mem_busy  in  1  data memory not ready
- pc_en  out  1  PC update enable
- ifid_en  out  1  IF/ID buffer load enable
- ifid_flush  out  1  IF/ID buffer clear to NOP
- idex_bubble  out  1  inject NOP into ID/EX
- pipe_en  out  1  EX/MEM/WB advance enable
- state  out  2  registered state: 00 RUN, 01 STALL, 10 MEMWAIT, 11 FLUSH
- stall_cnt  out  8  saturating count of non-RUN cycles

Function
REQ-003 The opcode classes SHALL be:
- 0000: NOP, no reads, no write.
- 0001-0111: ALU, reads a and b, writes dest.
- 1000: LOAD, no register reads, writes dest, load flag set.
- 1001: STORE, reads a, no write.
- 1100: BRANCH, reads a and b, no write.
- All other opcodes: NOP.
REQ-004 The block SHALL hold a 3-entry scoreboard (EX, MEM, WB); each entry holds {valid, dest, is_load}.
REQ-005 On each clock edge with mem_busy=0, the scoreboard SHALL shift: WB<=MEM, MEM<=EX, EX<=issued instruction's write info (valid=0 when no issue or a non-writing instruction).
REQ-006 The hazard signal SHALL be set when id_valid=1 and any register read by the ID instruction equals the dest of a valid scoreboard entry (see REQ-016 for the variant).
REQ-007 issue SHALL equal id_valid & !hazard & !br_taken & !mem_busy.
REQ-008 Combinational decision priority SHALL be mem_busy > br_taken > hazard > run.
REQ-009 MEMWAIT (mem_busy=1): pc_en=0, ifid_en=0, pipe_en=0, ifid_flush=0, idex_bubble=0; the scoreboard is held.
REQ-010 FLUSH (br_taken=1, mem_busy=0): pc_en=1, ifid_en=1, ifid_flush=1, idex_bubble=1, pipe_en=1.
REQ-011 A br_taken asserted during mem_busy SHALL be acted on only in the first cycle with mem_busy=0.
REQ-012 STALL (hazard=1): pc_en=0, ifid_en=0, idex_bubble=1, pipe_en=1, ifid_flush=0.
REQ-013 RUN: pc_en=1, ifid_en=1, pipe_en=1, ifid_flush=0, idex_bubble=0.
REQ-014 The state register SHALL capture each cycle's decision code at the clock edge.
REQ-015 stall_cnt SHALL increment on every edge whose decision is not RUN and SHALL saturate at 255, with no wrap.

Configuration
REQ-016 With macro PIPE_FORWARD_EN defined, hazard SHALL consider only the EX entry, and only when its is_load=1 (load-use stall of exactly 1 cycle).
REQ-017 Without PIPE_FORWARD_EN, hazard SHALL consider the EX, MEM and WB entries (no forwarding, no same-cycle register-file bypass; maximum stall 3 cycles).

Reset
REQ-018 While rst=1: pc_en=0, ifid_en=0, pipe_en=0, ifid_flush=0, idex_bubble=1.
REQ-019 On rst=1: all scoreboard valid bits SHALL clear, state SHALL be 00 and stall_cnt SHALL be 0, immediately and independent of clk.
REQ-020 Reset asserted mid-stall SHALL discard the pending hazard; the first cycle after release SHALL be RUN if id_valid=0.

Verification
REQ-021 No forwarding: ALU dest=3, then ALU reading a=3 -> 3 STALL cycles (idex_bubble=1, pc_en=0), then issue; stall_cnt=3.
REQ-022 PIPE_FORWARD_EN: LOAD dest=5, then ALU reading b=5 -> exactly 1 STALL cycle; ALU followed by a dependent ALU -> 0 stalls.
REQ-023 br_taken=1 with id_valid=1 and a hazard present -> ifid_flush=1, idex_bubble=1, pc_en=1; the EX entry is empty the next cycle.
REQ-024 mem_busy=1 for 4 cycles during a stall -> all enables 0 and the scoreboard frozen; the stall resumes with its remaining count after release; state=10 during the wait.
REQ-025 300 consecutive stall/wait cycles -> stall_cnt=255 and no wrap; rst pulse mid-stall -> state=00, stall_cnt=0, pc_en=1 after release.
